// File: rtl/status_flags_unit.sv
// 6502 processor status register (P): merges pipelined ALU flags, direct flag
// writes, PLP/BIT loads and interrupt entry, and evaluates branch conditions.
module status_flags_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_upd_en,
    input  logic [6:0] alu_upd_mask,
    input  logic [6:0] alu_flags,
    input  logic       flag_wr_en,
    input  logic [2:0] flag_wr_sel,
    input  logic       flag_wr_val,
    input  logic       irq_enter,
    input  logic       plp_load,
    input  logic       bit_load,
    input  logic [7:0] data_in,
    input  logic       push_brk,
    input  logic [2:0] branch_cond,
    output logic [6:0] status_flags,
    output logic [7:0] status_byte,
    output logic       flags_pending,
    output logic       branch_taken
);

    localparam logic [6:0] P_RESET  = 7'b0000100;
    localparam logic [6:0] B_MASK_N = 7'b1101111;

    logic [6:0] p_q;
    logic [6:0] p_next;
    logic [6:0] pend_mask;
    logic       pend_valid;
    logic       sel_flag;

    // Sources are applied lowest priority first so higher ones overwrite per bit.
    always_comb begin
        p_next = p_q;
        if (pend_valid) begin
            p_next = (p_q & ~pend_mask) | (alu_flags & pend_mask);
        end
        if (bit_load) begin
            p_next[6] = data_in[7];
            p_next[5] = data_in[6];
        end
        if (flag_wr_en) begin
            for (int i = 0; i < 7; i++) begin
                if (i != 4 && flag_wr_sel == 3'(i)) begin
                    p_next[i] = flag_wr_val;
                end
            end
        end
        if (irq_enter) begin
            p_next[2] = 1'b1;
        end
        if (plp_load) begin
            p_next = {data_in[7], data_in[6], 1'b0, data_in[3:0]};
        end
        p_next[4] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q        <= P_RESET;
            pend_valid <= 1'b0;
            pend_mask  <= '0;
        end else begin
            p_q        <= p_next;
            pend_valid <= alu_upd_en;
            if (alu_upd_en) begin
                pend_mask <= alu_upd_mask & B_MASK_N;
            end
        end
    end

    // Pairs of conditions share a flag; the low bit picks branch-if-set.
    always_comb begin
        sel_flag = 1'b0;
        case (branch_cond[2:1])
            2'd0: sel_flag = p_q[6];
            2'd1: sel_flag = p_q[5];
            2'd2: sel_flag = p_q[0];
            2'd3: sel_flag = p_q[1];
            default: sel_flag = 1'b0;
        endcase
    end

    assign branch_taken  = sel_flag ~^ branch_cond[0];
    assign status_flags  = p_q;
    assign status_byte   = {p_q[6], p_q[5], 1'b1, push_brk, p_q[3:0]};
    assign flags_pending = pend_valid;

endmodule
